mem_port_arbiter: RTL and testbench

- Arbitrates a single-ported unified memory between two requesters of the multicycle CPU: instruction fetch (IF) and data access (LW/SW).
- Each requester uses a req/ack handshake; the arbiter grants one access at a time and drives the memory port.
- The arbiter holds the address and data stable for a fixed memory latency, then returns read data with a one-cycle ack.
- It sits between the control-unit-sequenced datapath (PC/IR fetch path, LW/SW memory stage) and the memory.

---
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Round-robin on ties, fixed MEM_LAT access window, one-cycle ack pulse.
module mem_port_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             owner_d;
    logic             busy_d;
    logic             mem_en_d;
    logic             mem_we_d;
    logic [AW-1:0]    mem_addr_d;
    logic [DW-1:0]    mem_wdata_d;
    logic             if_ack_d;
    logic             d_ack_d;
    logic [DW-1:0]    if_rdata_d;
    logic [DW-1:0]    d_rdata_d;
    logic             gnt_data;

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= 1'b0;
            owner     <= 1'b0;
            busy      <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            owner     <= owner_d;
            busy      <= busy_d;
            mem_en    <= mem_en_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            if_ack    <= if_ack_d;
            d_ack     <= d_ack_d;
            if_rdata  <= if_rdata_d;
            d_rdata   <= d_rdata_d;
        end
    end

    // On a tie the port that did not win last time gets the grant.
    assign gnt_data = d_req && (!if_req || !last_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        owner_d     = owner;
        busy_d      = busy;
        mem_en_d    = mem_en;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        if_rdata_d  = if_rdata;
        d_rdata_d   = d_rdata;

        case (state_q)
            IDLE: begin
                busy_d   = 1'b0;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
                if (if_req || d_req) begin
                    mem_addr_d  = gnt_data ? d_addr : if_addr;
                    mem_wdata_d = gnt_data ? d_wdata : '0;
                    mem_we_d    = gnt_data && d_we;
                    mem_en_d    = 1'b1;
                    busy_d      = 1'b1;
                    owner_d     = gnt_data;
                    last_d      = gnt_data;
                    cnt_d       = CNT_INIT;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    if (!mem_we) begin
                        if (owner) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            if_rdata_d = mem_rdata;
                        end
                    end
                    d_ack_d  = owner;
                    if_ack_d = !owner;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d   = 1'b0;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, tie/stream/abandon/reset
// sequences, and an ack scoreboard fed by the stimulus.
module tb_mem_port_arbiter;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned LAT = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, d_req, d_we;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic          if_ack, d_ack, mem_en, mem_we, busy, owner;
    logic [DW-1:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner)
    );

    // Memory model: 256 words, word-addressed by addr[9:2].
    logic [31:0] mem_arr [256];
    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = 32'hC0DE_0000 | 32'(i);
        mem_arr[16] = 32'h8C01_0004;
    end
    always @(posedge clk) if (mem_en && mem_we) mem_arr[mem_addr[9:2]] <= mem_wdata;
    assign mem_rdata = mem_arr[mem_addr[9:2]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic        port;
        logic        store;
        logic [31:0] rdata;
    } sb_t;
    sb_t sb[$];
    logic [31:0] exp_if_rdata = '0;
    logic [31:0] exp_d_rdata  = '0;

    // Scoreboard: every ack must match the next expected completion.
    always @(negedge clk) begin
        if (reset === 1'b1 && (if_ack || d_ack)) begin
            sb_t e;
            check("ack_exclusive", 32'(if_ack & d_ack), 32'd0);
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_ack: if_ack=%0b d_ack=%0b with no pending request", if_ack, d_ack);
            end else begin
                e = sb.pop_front();
                check("ack_port", 32'(d_ack), 32'(e.port));
                check("ack_owner", 32'(owner), 32'(e.port));
                if (!e.store) begin
                    if (e.port) exp_d_rdata = e.rdata;
                    else        exp_if_rdata = e.rdata;
                end
                check("if_rdata", if_rdata, exp_if_rdata);
                check("d_rdata", d_rdata, exp_d_rdata);
            end
        end
    end

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } vec_t;
    vec_t vecs [7];

    task automatic run_vec(input vec_t v);
        int t0, k;
        logic got;
        @(posedge clk); #1;
        if_addr = v.addr; d_addr = v.addr; d_we = v.we; d_wdata = v.wdata;
        if (v.port) d_req = 1'b1; else if_req = 1'b1;
        sb.push_back('{v.port, v.we, v.rdata});
        t0 = cyc; k = 0; got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            k = cyc - t0;
            if (k >= 1 && k <= int'(LAT)) begin
                check("access_mem_en", 32'(mem_en), 32'd1);
                check("access_mem_addr", mem_addr, v.addr);
                check("access_mem_we", 32'(mem_we), 32'(v.we));
                if (v.we) check("access_mem_wdata", mem_wdata, v.wdata);
                if (k == 1) begin
                    if_addr = ~v.addr; d_addr = ~v.addr; d_wdata = ~v.wdata; d_we = ~v.we;
                end
            end
            if (v.port ? d_ack : if_ack) got = 1'b1;
        end
        check("vec_ack_latency", got ? 32'(k) : 32'hFFFF_FFFF, 32'(LAT + 1));
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        check("vec_idle_after", 32'({busy, mem_en, if_ack, d_ack}), 32'd0);
    endtask

    // Both requesters active; each drops req on the edge after its ack.
    task automatic tie_run(input int exp_dk, input int exp_ik);
        int t0, k, dk, ik;
        logic drop_i, drop_d;
        t0 = cyc; dk = -1; ik = -1;
        for (int i = 0; i < 40 && (if_req || d_req); i++) begin
            @(negedge clk);
            k = cyc - t0;
            if (k == 1) check("tie_owner_data", 32'(owner), 32'd1);
            drop_i = if_ack; drop_d = d_ack;
            if (d_ack) dk = k;
            if (if_ack) ik = k;
            @(posedge clk); #1;
            if (drop_i) if_req = 1'b0;
            if (drop_d) d_req = 1'b0;
        end
        if_req = 1'b0; d_req = 1'b0;
        check("tie_d_ack_cycle", 32'(dk), 32'(exp_dk));
        check("tie_if_ack_cycle", 32'(ik), 32'(exp_ik));
    endtask

    initial begin
        int n_ack, last_ack, t0, k;
        logic got;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,         32'h8C01_0004};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0080, 32'h0,         32'hC0DE_0020};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0,         32'hC0DE_00FF};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_03FC, 32'h1234_5678, 32'h0};
        vecs[6] = '{1'b0, 1'b0, 32'h0000_03FC, 32'h0,         32'h1234_5678};

        // Reset with both requests pending.
        reset = 1'b0; if_req = 1'b1; d_req = 1'b1;
        d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; if_addr = 32'h40;
        repeat (3) begin
            @(negedge clk);
            check("reset_ctrl", 32'({mem_en, mem_we, busy, if_ack, d_ack, owner}), 32'd0);
            check("reset_data", mem_addr | mem_wdata | if_rdata | d_rdata, 32'd0);
        end

        // Tie after reset: store wins, then fetch.
        @(posedge clk); #1;
        reset = 1'b1;
        sb.push_back('{1'b1, 1'b1, 32'h0});
        sb.push_back('{1'b0, 1'b0, 32'h8C01_0004});
        tie_run(int'(LAT) + 1, 2 * int'(LAT) + 3);

        // Second tie: last grant was IF, so data wins again.
        @(posedge clk); #1;
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; if_addr = 32'h80;
        sb.push_back('{1'b1, 1'b0, 32'hDEAD_BEEF});
        sb.push_back('{1'b0, 1'b0, 32'hC0DE_0020});
        tie_run(int'(LAT) + 1, 2 * int'(LAT) + 3);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Continuous fetch stream; data joins mid-stream and then alternates.
        sb.push_back('{1'b0, 1'b0, 32'h8C01_0004});
        sb.push_back('{1'b0, 1'b0, 32'h8C01_0004});
        sb.push_back('{1'b0, 1'b0, 32'h8C01_0004});
        sb.push_back('{1'b1, 1'b0, 32'hC0DE_0081});
        sb.push_back('{1'b0, 1'b0, 32'h8C01_0004});
        sb.push_back('{1'b1, 1'b0, 32'hC0DE_0081});
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h40; d_we = 1'b0; d_addr = 32'h204;
        n_ack = 0; last_ack = -1;
        for (int i = 0; i < 80 && n_ack < 6; i++) begin
            @(negedge clk);
            if (if_ack || d_ack) begin
                n_ack++;
                if (last_ack >= 0) check("stream_spacing", 32'(cyc - last_ack), 32'(LAT + 2));
                last_ack = cyc;
                if (n_ack == 2) begin
                    @(posedge clk);
                    @(posedge clk); #1;
                    d_req = 1'b1;
                end
            end
        end
        check("stream_ack_count", 32'(n_ack), 32'd6);
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0;

        // Load whose req is dropped in its first access cycle still completes.
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        sb.push_back('{1'b1, 1'b0, 32'hC0DE_0080});
        t0 = cyc;
        @(posedge clk); #1;
        d_req = 1'b0;
        got = 1'b0; k = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            k = cyc - t0;
            if (d_ack) got = 1'b1;
        end
        check("abandon_ack_latency", got ? 32'(k) : 32'hFFFF_FFFF, 32'(LAT + 1));

        // Reset during the second access cycle of a store.
        @(posedge clk); #1;
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'hFACE_FACE;
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_mem_we", 32'(mem_we), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0; d_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midreset_ctrl", 32'({mem_en, mem_we, busy, d_ack, if_ack}), 32'd0);
        check("midreset_rdata", if_rdata | d_rdata, 32'd0);
        exp_if_rdata = '0; exp_d_rdata = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("post_reset_quiet", 32'({busy, d_ack, mem_en}), 32'd0);
        end

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
